rg_ifr_md: RTL and testbench
============================

# rg_ifr_md

Parametrised interrupt-flag/mask register pair for the peripheral register file: hardware event inputs set per-bit flags, software clears flags by writing one, and a mask register gates a prioritised interrupt request toward the interrupt controller. It extends the single 8-bit data register with event capture, write-one-to-clear semantics, vector acknowledge handling and per-bit implementation masking. One instance sits behind each peripheral's IFR/IMSK I/O address pair.

## Interface
- P_WIDTH, 8: number of flag/mask bits, 1..16
- P_INIT_VAL, all 0: flag reset value per bit; also the constant read value of unimplemented bits
- P_IMPL_MASK, all 1: 1 = bit implemented; 0 = bit reads P_INIT_VAL, ignores writes/events, never requests
- P_EDGE_MASK, all 0: 1 = evt bit is a level, rising edge sets the flag; 0 = evt bit is a one-cycle pulse
- P_HW_CLR_MASK, all 1: 1 = flag cleared by vector acknowledge; 0 = software clear only
- clk  input  1  clock
- nrst  input  1  reset, asynchronous, active-low
- wdata  input  P_WIDTH  write data for both registers
- fwbe  input  1  flag register write strobe (write-one-to-clear)
- mwbe  input  1  mask register write strobe (plain write)
- evt  input  P_WIDTH  hardware event inputs
- irq_ack  input  1  vector acknowledge, one cycle
- frdata  output  P_WIDTH  flag register contents
- mrdata  output  P_WIDTH  mask register contents
- irq  output  1  interrupt request
- irq_idx  output  4  index of highest-priority pending bit

## Operation
- Flag register (per implemented bit i), next-state priority: set event > clear; clear = (fwbe & wdata[i]) | (irq_ack & irq & irq_idx==i & P_HW_CLR_MASK[i]).
- Set event: pulse bits: evt_s[i]==1; edge bits: evt_s[i]==1 & evt_prev[i]==0. evt_s is evt or its synchronised copy (see Configuration).
- fwbe with wdata[i]==0 leaves bit i unchanged; writing 1 to a clear flag has no effect.
- Mask register: on mwbe, mask[i] <= wdata[i] for implemented bits; unimplemented mask bits fixed 0.
- pending = flag & mask & P_IMPL_MASK; irq = |pending; irq_idx = lowest set index of pending (bit 0 highest priority), 0 when irq==0.
- irq_ack while irq==0: ignored. Ack clears only the bit indexed at the ack cycle.
- fwbe and mwbe in the same cycle: both take effect independently.
- Reset: flags = P_INIT_VAL & P_IMPL_MASK (unimplemented bits read P_INIT_VAL), mask = 0, evt_prev = 0, synchroniser flops = 0, irq = 0, irq_idx = 0.
- Level input already high at reset release counts as a rising edge on its first sampled cycle.

## Timing
- Flags, mask, evt_prev registered on posedge clk; irq/irq_idx combinational from registered flag/mask (no extra cycle).
- Event latency: evt sampled at edge n -> frdata and irq valid after edge n (1 cycle); +2 cycles with synchroniser.
- Software clear: fwbe at edge n -> flag 0 after edge n; irq drops same cycle if no other pending bit.
- Ack: irq_ack at edge n -> flag[irq_idx] 0 after edge n; irq_idx advances to next pending bit in cycle n+1.
- Set and clear (write or ack) on same bit, same edge: flag ends 1.
- Reset assertion mid-operation: all state returns to reset values asynchronously; pending events are lost.

## Configuration
- RG_IFR_SYNC_EN defined: evt passes through a two-flop synchroniser per implemented bit before edge/pulse detection; pulse-mode inputs must then be held at least 2 clk cycles' worth of stable width (pulse mode treats each synchronised high cycle as a set).
- Undefined: evt used directly, 1-cycle event latency; sources must be clk-synchronous.

## Test plan
- Reset with P_INIT_VAL=8'h80, P_IMPL_MASK=8'h7F -> frdata=8'h80, mrdata=0, irq=0; fwbe wdata=8'hFF -> frdata stays 8'h80.
- evt=8'h24 one cycle, mask=8'h20 -> frdata=8'h24, irq=1, irq_idx=5; irq_ack -> frdata=8'h04, irq=0.
- Flags 8'h0C, mask 8'hFF -> irq_idx=2; fwbe wdata=8'h04 -> frdata=8'h08, irq_idx=3; fwbe wdata=8'h00 -> unchanged.
- Bit 1 pulse event coincident with fwbe wdata=8'h02 and with irq_ack on idx 1 -> flag 1 stays set.
- P_EDGE_MASK=8'h01, evt[0] held high 10 cycles -> flag set once; after clear stays 0 until evt[0] falls and rises again.
- With RG_IFR_SYNC_EN: evt[3] pulse of 3 cycles -> flag[3] set 3 cycles after first high sample; P_HW_CLR_MASK[3]=0 -> irq_ack leaves flag set.

Source files
------------

// File: rtl/rg_ifr_md.sv
// rg_ifr_md: interrupt flag / mask register pair with prioritised request.
// Hardware events set flags; software clears them by writing one (W1C).
// A vector acknowledge clears the indexed flag for the bits that allow it.
// Optional feature macro: RG_IFR_SYNC_EN adds a two-flop synchroniser on evt.
module rg_ifr_md #(
    parameter int unsigned        P_WIDTH       = 8,
    parameter logic [P_WIDTH-1:0] P_INIT_VAL    = '0,
    parameter logic [P_WIDTH-1:0] P_IMPL_MASK   = '1,
    parameter logic [P_WIDTH-1:0] P_EDGE_MASK   = '0,
    parameter logic [P_WIDTH-1:0] P_HW_CLR_MASK = '1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [P_WIDTH-1:0] wdata,
    input  logic               fwbe,
    input  logic               mwbe,
    input  logic [P_WIDTH-1:0] evt,
    input  logic               irq_ack,
    output logic [P_WIDTH-1:0] frdata,
    output logic [P_WIDTH-1:0] mrdata,
    output logic               irq,
    output logic [3:0]         irq_idx
);

    logic [P_WIDTH-1:0] r_flag;
    logic [P_WIDTH-1:0] r_mask;
    logic [P_WIDTH-1:0] r_evt_prev;

    logic [P_WIDTH-1:0] w_evt_s;
    logic [P_WIDTH-1:0] w_set;
    logic [P_WIDTH-1:0] w_clr;
    logic [P_WIDTH-1:0] w_pending;
    logic [P_WIDTH-1:0] w_ack_sel;
    logic [P_WIDTH-1:0] w_flag_nxt;
    logic [3:0]         w_idx;
    logic               w_irq;

`ifdef RG_IFR_SYNC_EN
    logic [P_WIDTH-1:0] r_sync1;
    logic [P_WIDTH-1:0] r_sync2;

    // Two-flop synchroniser for asynchronous event sources
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= evt & P_IMPL_MASK;
            r_sync2 <= r_sync1;
        end
    end

    assign w_evt_s = r_sync2;
`else
    assign w_evt_s = evt & P_IMPL_MASK;
`endif

    // Pulse bits set on every high sample, edge bits only on a rising edge
    assign w_set = w_evt_s & (~P_EDGE_MASK | ~r_evt_prev);

    assign w_pending = r_flag & r_mask & P_IMPL_MASK;
    assign w_irq     = |w_pending;

    // Lowest pending index wins; scan downward so the last hit is the lowest
    always_comb begin
        w_idx = 4'd0;
        for (int i = int'(P_WIDTH) - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    // One-hot decode of the currently requested vector
    always_comb begin
        w_ack_sel = '0;
        for (int i = 0; i < int'(P_WIDTH); i++) begin
            w_ack_sel[i] = (w_idx == 4'(i));
        end
    end

    // Clear sources: W1C write and acknowledge of the active vector
    always_comb begin
        w_clr = '0;
        if (fwbe) begin
            w_clr = w_clr | wdata;
        end
        if (irq_ack && w_irq) begin
            w_clr = w_clr | (w_ack_sel & P_HW_CLR_MASK);
        end
    end

    // Set wins over clear when both hit the same bit on one edge
    assign w_flag_nxt = ((r_flag & ~w_clr) | w_set) & P_IMPL_MASK;

    // Flag, mask and edge-history registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_flag     <= P_INIT_VAL & P_IMPL_MASK;
            r_mask     <= '0;
            r_evt_prev <= '0;
        end else begin
            r_flag     <= w_flag_nxt;
            r_evt_prev <= w_evt_s;
            if (mwbe) begin
                r_mask <= wdata & P_IMPL_MASK;
            end
        end
    end

    assign frdata  = r_flag | (P_INIT_VAL & ~P_IMPL_MASK);
    assign mrdata  = r_mask;
    assign irq     = w_irq;
    assign irq_idx = w_idx;

endmodule

// File: tb/tb_rg_ifr_md.sv
// Self-checking bench for rg_ifr_md (8 bits, bit 7 unimplemented, bit 0 edge,
// bit 3 software-clear only). Expected {frdata,mrdata,irq,irq_idx} tuples are
// queued as stimulus is driven and popped when the DUT output is sampled.
module tb_rg_ifr_md;

`ifdef RG_IFR_SYNC_EN
    localparam int LAT  = 3;
    localparam int HOLD = 3;
`else
    localparam int LAT  = 1;
    localparam int HOLD = 1;
`endif

    typedef struct packed {
        logic [7:0] fr;
        logic [7:0] mr;
        logic       irq;
        logic [3:0] idx;
    } obs_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] wdata;
    logic       fwbe;
    logic       mwbe;
    logic [7:0] evt;
    logic       irq_ack;
    logic [7:0] frdata;
    logic [7:0] mrdata;
    logic       irq;
    logic [3:0] irq_idx;

    int   checks   = 0;
    int   failures = 0;
    obs_t sb[$];
    obs_t got;
    obs_t exp_v;

    rg_ifr_md #(
        .P_WIDTH      (8),
        .P_INIT_VAL   (8'h80),
        .P_IMPL_MASK  (8'h7F),
        .P_EDGE_MASK  (8'h01),
        .P_HW_CLR_MASK(8'hF7)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .wdata  (wdata),
        .fwbe   (fwbe),
        .mwbe   (mwbe),
        .evt    (evt),
        .irq_ack(irq_ack),
        .frdata (frdata),
        .mrdata (mrdata),
        .irq    (irq),
        .irq_idx(irq_idx)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; wdata = '0; fwbe = 0; mwbe = 0; evt = '0; irq_ack = 0;
        sb.push_back('{8'h80, 8'h00, 1'b0, 4'd0});
        #2;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL reset_state got=%h exp=%h", got, exp_v); end
        tick(2);
        nrst = 1'b1;
        tick(1);
        fwbe = 1; wdata = 8'hFF;
        sb.push_back('{8'h80, 8'h00, 1'b0, 4'd0});
        tick(1); fwbe = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL w1c_unimpl got=%h exp=%h", got, exp_v); end
        mwbe = 1; wdata = 8'hFF;
        sb.push_back('{8'h80, 8'h7F, 1'b0, 4'd0});
        tick(1); mwbe = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL mask_impl got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_event_ack();
        mwbe = 1; wdata = 8'h20; tick(1); mwbe = 0;
        evt = 8'h24;
        sb.push_back('{8'hA4, 8'h20, 1'b1, 4'd5});
        tick(1); evt = '0; tick(LAT - 1);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL event_set got=%h exp=%h", got, exp_v); end
        irq_ack = 1;
        sb.push_back('{8'h84, 8'h20, 1'b0, 4'd0});
        tick(1); irq_ack = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL ack_clear got=%h exp=%h", got, exp_v); end
        irq_ack = 1;
        sb.push_back('{8'h84, 8'h20, 1'b0, 4'd0});
        tick(1); irq_ack = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL ack_idle got=%h exp=%h", got, exp_v); end
        fwbe = 1; wdata = 8'h04; tick(1); fwbe = 0;
    endtask

    task automatic test_priority();
        mwbe = 1; wdata = 8'hFF; tick(1); mwbe = 0;
        evt = 8'h0C;
        sb.push_back('{8'h8C, 8'h7F, 1'b1, 4'd2});
        tick(1); evt = '0; tick(LAT - 1);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL prio_idx2 got=%h exp=%h", got, exp_v); end
        fwbe = 1; wdata = 8'h04;
        sb.push_back('{8'h88, 8'h7F, 1'b1, 4'd3});
        tick(1); fwbe = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL w1c_bit2 got=%h exp=%h", got, exp_v); end
        fwbe = 1; wdata = 8'h00;
        sb.push_back('{8'h88, 8'h7F, 1'b1, 4'd3});
        tick(1); fwbe = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL w1c_zero got=%h exp=%h", got, exp_v); end
        fwbe = 1; wdata = 8'h08;
        sb.push_back('{8'h80, 8'h7F, 1'b0, 4'd0});
        tick(1); fwbe = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL w1c_last got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_set_clear_collision();
        evt = 8'h02;
        repeat (LAT - 1) begin tick(1); evt = '0; end
        fwbe = 1; wdata = 8'h02;
        sb.push_back('{8'h82, 8'h7F, 1'b1, 4'd1});
        tick(1); fwbe = 0; evt = '0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL set_vs_w1c got=%h exp=%h", got, exp_v); end
        evt = 8'h02;
        repeat (LAT - 1) begin tick(1); evt = '0; end
        irq_ack = 1;
        sb.push_back('{8'h82, 8'h7F, 1'b1, 4'd1});
        tick(1); irq_ack = 0; evt = '0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL set_vs_ack got=%h exp=%h", got, exp_v); end
        fwbe = 1; wdata = 8'h02; tick(1); fwbe = 0;
    endtask

    task automatic test_edge();
        evt = 8'h01;
        sb.push_back('{8'h81, 8'h7F, 1'b1, 4'd0});
        tick(LAT);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL edge_rise got=%h exp=%h", got, exp_v); end
        tick(2);
        fwbe = 1; wdata = 8'h01; tick(1); fwbe = 0;
        sb.push_back('{8'h80, 8'h7F, 1'b0, 4'd0});
        tick(4);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL edge_held got=%h exp=%h", got, exp_v); end
        evt = '0;
        sb.push_back('{8'h80, 8'h7F, 1'b0, 4'd0});
        tick(LAT + 1);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL edge_fall got=%h exp=%h", got, exp_v); end
        evt = 8'h01;
        sb.push_back('{8'h81, 8'h7F, 1'b1, 4'd0});
        tick(LAT);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL edge_rerise got=%h exp=%h", got, exp_v); end
        evt = '0; tick(LAT + 1);
        fwbe = 1; wdata = 8'h01; tick(1); fwbe = 0;
    endtask

    task automatic test_hw_clr_mask();
        evt = 8'h08;
        sb.push_back('{8'h88, 8'h7F, 1'b1, 4'd3});
        tick(HOLD); evt = '0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL bit3_set got=%h exp=%h", got, exp_v); end
        tick(LAT);
        irq_ack = 1;
        sb.push_back('{8'h88, 8'h7F, 1'b1, 4'd3});
        tick(1); irq_ack = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL ack_sw_only got=%h exp=%h", got, exp_v); end
        fwbe = 1; wdata = 8'h08;
        sb.push_back('{8'h80, 8'h7F, 1'b0, 4'd0});
        tick(1); fwbe = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL bit3_w1c got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_back_to_back();
        evt = 8'h06;
        sb.push_back('{8'h86, 8'h7F, 1'b1, 4'd1});
        tick(1); evt = '0; tick(LAT - 1);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL b2b_start got=%h exp=%h", got, exp_v); end
        irq_ack = 1;
        sb.push_back('{8'h84, 8'h7F, 1'b1, 4'd2});
        sb.push_back('{8'h80, 8'h7F, 1'b0, 4'd0});
        tick(1);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL b2b_ack1 got=%h exp=%h", got, exp_v); end
        tick(1); irq_ack = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL b2b_ack2 got=%h exp=%h", got, exp_v); end
        evt = 8'h10;
        tick(1); evt = '0; tick(LAT - 1);
        fwbe = 1; mwbe = 1; wdata = 8'h10;
        sb.push_back('{8'h80, 8'h10, 1'b0, 4'd0});
        tick(1); fwbe = 0; mwbe = 0;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL fwbe_mwbe got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_async_reset();
        evt = 8'h10;
        sb.push_back('{8'h90, 8'h10, 1'b1, 4'd4});
        tick(1); evt = '0; tick(LAT - 1);
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL pre_reset got=%h exp=%h", got, exp_v); end
        #2 nrst = 1'b0;
        sb.push_back('{8'h80, 8'h00, 1'b0, 4'd0});
        #1;
        got = '{frdata, mrdata, irq, irq_idx}; exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin failures++; $display("FAIL async_reset got=%h exp=%h", got, exp_v); end
        tick(1);
        nrst = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_event_ack();
        test_priority();
        test_set_clear_collision();
        test_edge();
        test_hw_clr_mask();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
